// File: rtl/lc3_mmio_pkg.sv
// Shared register map, bit positions and address decode for the LC-3 MMIO responder.
// The timer entries are decoded only when LC3_MMIO_TIMER_EN is defined.
package lc3_mmio_pkg;

  localparam logic [15:0] OFF_KBSR = 16'h0000;
  localparam logic [15:0] OFF_KBDR = 16'h0002;
  localparam logic [15:0] OFF_DSR  = 16'h0004;
  localparam logic [15:0] OFF_DDR  = 16'h0006;
  localparam logic [15:0] OFF_TMCR = 16'h0008;
  localparam logic [15:0] OFF_TMLD = 16'h000A;

  localparam int BIT_RDY = 15;
  localparam int BIT_IE  = 14;
  localparam int BIT_OVF = 0;
  localparam int BIT_EXP = 15;
  localparam int BIT_EN  = 0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_KBSR,
    SEL_KBDR,
    SEL_DSR,
    SEL_DDR,
    SEL_TMCR,
    SEL_TMLD
  } reg_sel_e;

  // Full 16-bit compare against each register: no aliasing anywhere in the window.
  function automatic reg_sel_e decode_addr(input logic [15:0] addr, input logic [15:0] base);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (addr == base + OFF_KBSR) sel = SEL_KBSR;
    if (addr == base + OFF_KBDR) sel = SEL_KBDR;
    if (addr == base + OFF_DSR)  sel = SEL_DSR;
    if (addr == base + OFF_DDR)  sel = SEL_DDR;
`ifdef LC3_MMIO_TIMER_EN
    if (addr == base + OFF_TMCR) sel = SEL_TMCR;
    if (addr == base + OFF_TMLD) sel = SEL_TMLD;
`endif
    return sel;
  endfunction

endpackage

// File: rtl/lc3_mmio_txfifo.sv
// Display TX FIFO: power-of-two depth, registered push/pop, fullness judged before the edge.
// Handshake: a push is taken when i_push & ~o_full, a pop when i_pop & ~o_empty, both at the rising edge.
module lc3_mmio_txfifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output logic [7:0] o_head,
  output logic [AW:0] o_count
);

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  // Head reads as zero while empty so stale entries never leak onto the display port.
  assign o_head    = o_empty ? 8'h00 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lc3_mmio_responder.sv
// LC-3 memory-mapped keyboard/display target with TX FIFO and level INT request.
// Define LC3_MMIO_TIMER_EN to add the TMCR/TMLD interval timer.
module lc3_mmio_responder
  import lc3_mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFE00,
  parameter int          TX_DEPTH  = 4,
  parameter int          TX_AW     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] memA,
  inout  wire  [15:0] memD,
  input  logic        rc,
  input  logic        wc,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        dsp_valid,
  output logic [7:0]  dsp_data,
  input  logic        dsp_ready,
  output logic        INT
);

  reg_sel_e       w_sel;
  logic           w_rd_hit;
  logic           w_wr_hit;
  logic [15:0]    w_rd_data;
  logic           w_kb_accept;
  logic           w_kbdr_read;
  logic           w_ddr_write;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [7:0]     w_head;
  logic [TX_AW:0] w_count;
  logic           w_tm_irq;

  logic           r_kb_rdy;
  logic           r_kb_ie;
  logic [7:0]     r_kbdr;
  logic           r_dsr_ie;
  logic           r_ovf;
  logic           r_int;

  assign w_sel       = decode_addr(memA, BASE_ADDR);
  assign w_rd_hit    = rc & (w_sel != SEL_NONE);
  assign w_wr_hit    = wc & (w_sel != SEL_NONE);
  assign w_kb_accept = kb_valid & ~r_kb_rdy;
  assign w_kbdr_read = rc & (w_sel == SEL_KBDR);
  assign w_ddr_write = w_wr_hit & (w_sel == SEL_DDR);
  assign w_push      = w_ddr_write & ~w_full;
  assign w_pop       = ~w_empty & dsp_ready;

  assign kb_ready  = ~r_kb_rdy;
  assign dsp_valid = ~w_empty;
  assign dsp_data  = w_head;
  assign INT       = r_int;

  lc3_mmio_txfifo #(
    .DEPTH (TX_DEPTH),
    .AW    (TX_AW)
  ) u_txfifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_data  (memD[7:0]),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_count (w_count)
  );

`ifdef LC3_MMIO_TIMER_EN
  logic        r_tm_en;
  logic        r_tm_ie;
  logic        r_tm_exp;
  logic [15:0] r_tmld;
  logic [15:0] r_tm_cnt;
  logic        w_tmcr_write;

  assign w_tmcr_write = w_wr_hit & (w_sel == SEL_TMCR);
  assign w_tm_irq     = r_tm_exp & r_tm_ie;

  // Counter runs TMLD..0, so the expiry period is TMLD+1 cycles; a TMCR write re-arms it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tm_en  <= 1'b0;
      r_tm_ie  <= 1'b0;
      r_tm_exp <= 1'b0;
      r_tmld   <= '0;
      r_tm_cnt <= '0;
    end else begin
      if (w_wr_hit && (w_sel == SEL_TMLD)) r_tmld <= memD;
      if (w_tmcr_write) begin
        r_tm_ie  <= memD[BIT_IE];
        r_tm_en  <= memD[BIT_EN];
        r_tm_exp <= 1'b0;
        if (memD[BIT_EN]) r_tm_cnt <= r_tmld;
      end else if (r_tm_en) begin
        if (r_tm_cnt == '0) begin
          r_tm_exp <= 1'b1;
          r_tm_cnt <= r_tmld;
        end else begin
          r_tm_cnt <= r_tm_cnt - 1'b1;
        end
      end
    end
  end
`else
  assign w_tm_irq = 1'b0;
`endif

  always_comb begin
    w_rd_data = 16'h0000;
    case (w_sel)
      SEL_KBSR: w_rd_data = {r_kb_rdy, r_kb_ie, 14'b0};
      SEL_KBDR: w_rd_data = {8'b0, r_kbdr};
      SEL_DSR:  w_rd_data = {~w_full, r_dsr_ie, 13'b0, r_ovf};
      SEL_DDR:  w_rd_data = 16'h0000;
`ifdef LC3_MMIO_TIMER_EN
      SEL_TMCR: w_rd_data = {r_tm_exp, r_tm_ie, 13'b0, r_tm_en};
      SEL_TMLD: w_rd_data = r_tmld;
`endif
      default:  w_rd_data = 16'h0000;
    endcase
  end

  // Main memory shares the bus, so release it for every address outside the window.
  assign memD = w_rd_hit ? w_rd_data : 16'hzzzz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_kb_rdy <= 1'b0;
      r_kb_ie  <= 1'b0;
      r_kbdr   <= 8'h00;
    end else begin
      if (w_wr_hit && (w_sel == SEL_KBSR)) r_kb_ie <= memD[BIT_IE];
      if (w_kb_accept) begin
        r_kbdr   <= kb_data;
        r_kb_rdy <= 1'b1;
      end else if (w_kbdr_read) begin
        r_kb_rdy <= 1'b0;
      end
    end
  end

  // Overflow records a DDR write dropped because the FIFO was full before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dsr_ie <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_hit && (w_sel == SEL_DSR)) begin
        r_dsr_ie <= memD[BIT_IE];
        r_ovf    <= 1'b0;
      end else if (w_ddr_write && w_full) begin
        r_ovf    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_int <= 1'b0;
    end else begin
      r_int <= (r_kb_rdy & r_kb_ie) | (~w_full & r_dsr_ie) | w_tm_irq;
    end
  end

endmodule
